// File: rtl/sample_window_averager_pkg.sv
// Shared constants and state encoding for the sample window averager and its
// downstream threshold comparator.
package sample_window_averager_pkg;

  typedef enum logic {
    Accum   = 1'b0,
    Present = 1'b1
  } state_e;

  localparam int unsigned DATA_WIDTH_DEF    = 16;
  localparam int unsigned LOG2_WINDOW_DEF   = 2;
  localparam int unsigned ENABLE_CYCLES_DEF = 2;

  localparam logic [15:0] COMPARE_THRESHOLD = 16'd8;

endpackage

// File: rtl/sample_window_averager.sv
// Sums windows of 2^log2_window samples and presents each window's floor mean to
// the comparator, holding compare_enable high for enable_cycles cycles.
module sample_window_averager
  import sample_window_averager_pkg::*;
#(
  parameter int unsigned data_width    = DATA_WIDTH_DEF,
  parameter int unsigned log2_window   = LOG2_WINDOW_DEF,
  parameter int unsigned enable_cycles = ENABLE_CYCLES_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sample_valid,
  input  logic [data_width-1:0] sample_data,
  output logic                  sample_ready,
  input  logic                  flush,
  output logic                  compare_enable,
  output logic [data_width-1:0] compare_data_out,
  output logic [15:0]           window_count
);

  localparam int unsigned AccWidth = data_width + log2_window;
  localparam int unsigned CntWidth = log2_window;
  localparam int unsigned EnWidth  = $clog2(enable_cycles + 1);

  // The comparator registers data one cycle before comparing it.
  if (enable_cycles < 2) begin : gen_enable_cycles_check
    $error("enable_cycles must be at least 2");
  end
  if (log2_window < 1 || log2_window > 8) begin : gen_log2_window_check
    $error("log2_window must be in 1..8");
  end

  state_e                state_q, state_d;
  logic [AccWidth-1:0]   acc_q, acc_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic [EnWidth-1:0]    en_cnt_q, en_cnt_d;
  logic                  ready_q, ready_d;
  logic                  enable_q, enable_d;
  logic [data_width-1:0] data_q, data_d;
  logic [15:0]           wcount_q, wcount_d;

  logic                  transfer;
  logic                  last_sample;
  logic                  en_done;
  logic [AccWidth-1:0]   sum;

  assign transfer    = sample_valid && ready_q;
  assign last_sample = (cnt_q == {CntWidth{1'b1}});
  assign en_done     = (en_cnt_q == EnWidth'(enable_cycles));
  assign sum         = acc_q + AccWidth'(sample_data);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= Accum;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      Accum:   if (!flush && transfer && last_sample) state_d = Present;
      Present: if (en_done) state_d = Accum;
      default: state_d = Accum;
    endcase
  end

  always_comb begin
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    en_cnt_d = en_cnt_q;
    ready_d  = ready_q;
    enable_d = enable_q;
    data_d   = data_q;
    wcount_d = wcount_q;
    unique case (state_q)
      Accum: begin
        ready_d  = 1'b1;
        enable_d = 1'b0;
        // Flush wins over a simultaneous transfer: the sample is consumed but dropped.
        if (flush) begin
          acc_d = '0;
          cnt_d = '0;
        end else if (transfer) begin
          if (last_sample) begin
            data_d   = data_width'(sum >> log2_window);
            acc_d    = '0;
            cnt_d    = '0;
            enable_d = 1'b1;
            ready_d  = 1'b0;
            en_cnt_d = EnWidth'(1);
          end else begin
            acc_d = sum;
            cnt_d = cnt_q + CntWidth'(1);
          end
        end
      end
      Present: begin
        if (en_done) begin
          enable_d = 1'b0;
          ready_d  = 1'b1;
          wcount_d = wcount_q + 16'd1;
        end else begin
          en_cnt_d = en_cnt_q + EnWidth'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      en_cnt_q <= '0;
      ready_q  <= 1'b0;
      enable_q <= 1'b0;
      data_q   <= '0;
      wcount_q <= '0;
    end else begin
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      en_cnt_q <= en_cnt_d;
      ready_q  <= ready_d;
      enable_q <= enable_d;
      data_q   <= data_d;
      wcount_q <= wcount_d;
    end
  end

  assign sample_ready     = ready_q;
  assign compare_enable   = enable_q;
  assign compare_data_out = data_q;
  assign window_count     = wcount_q;

endmodule

// File: tb/tb_sample_window_averager.sv
// Directed bench for sample_window_averager; expected window means are queued as
// samples are driven and checked when compare_enable rises.
module tb_sample_window_averager;
  import sample_window_averager_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sample_valid = 1'b0;
  logic [15:0] sample_data = '0;
  logic        flush = 1'b0;
  logic        sample_ready;
  logic        compare_enable;
  logic [15:0] compare_data_out;
  logic [15:0] window_count;

  sample_window_averager #(
    .data_width   (16),
    .log2_window  (2),
    .enable_cycles(2)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .sample_valid    (sample_valid),
    .sample_data     (sample_data),
    .sample_ready    (sample_ready),
    .flush           (flush),
    .compare_enable  (compare_enable),
    .compare_data_out(compare_data_out),
    .window_count    (window_count)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          fails = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: pops the scoreboard on each compare_enable rise, checks pulse shape on fall.
  logic        en_prev = 1'b0;
  int          run = 0;
  int          windows = 0;
  logic [15:0] cur_mean = '0;
  logic [15:0] exp_wc = '0;

  always @(negedge clk) begin
    if (!reset) begin
      en_prev = 1'b0;
      run     = 0;
      exp_wc  = '0;
    end else begin
      if (compare_enable) begin
        run++;
        check("ready_low_in_present", sample_ready, 0);
        if (!en_prev) begin
          check("window_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            cur_mean = exp_q.pop_front();
            check("mean", compare_data_out, cur_mean);
          end
        end
      end else if (en_prev) begin
        check("enable_run_length", run, 2);
        check("ready_after_present", sample_ready, 1);
        exp_wc++;
        check("window_count", window_count, exp_wc);
        check("mean_hold", compare_data_out, cur_mean);
        windows++;
        run = 0;
      end
      en_prev = compare_enable;
    end
  end

  task automatic send(input logic [15:0] d);
    int guard = 0;
    sample_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (sample_ready) begin
        sample_data = d;
        @(posedge clk);
        #1;
        break;
      end
      sample_data = 16'($urandom);
      guard++;
      if (guard > 50) begin
        check("send_timeout", sample_ready, 1);
        break;
      end
    end
  endtask

  task automatic window(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] c, input logic [15:0] d);
    logic [17:0] s;
    s = 18'(a) + 18'(b) + 18'(c) + 18'(d);
    exp_q.push_back(s[17:2]);
    send(a);
    send(b);
    send(c);
    send(d);
  endtask

  task automatic idle(input int n);
    sample_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] wc_before;
    int          w0;

    #12;
    check("reset_ready", sample_ready, 0);
    check("reset_enable", compare_enable, 0);
    check("reset_data", compare_data_out, 0);
    check("reset_wcount", window_count, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_reset", sample_ready, 1);

    window(16'd2, 16'd4, 16'd6, 16'd8);
    idle(4);
    check("wcount_first", window_count, 1);
    window(16'd8, 16'd9, 16'd10, 16'd9);
    idle(1);
    check("above_threshold", compare_data_out > COMPARE_THRESHOLD, 1);
    idle(3);
    window(16'd1, 16'd1, 16'd1, 16'd2);
    idle(4);
    window(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    window(16'd0, 16'd0, 16'd0, 16'd0);
    idle(4);

    // Partial window discarded by flush, including the sample transferred with it.
    send(16'd100);
    send(16'd100);
    flush        = 1'b1;
    sample_valid = 1'b1;
    sample_data  = 16'd50;
    @(posedge clk);
    #1;
    flush = 1'b0;
    wc_before = window_count;
    window(16'd12, 16'd12, 16'd12, 16'd12);
    idle(4);
    check("flush_one_window", window_count, 32'(wc_before) + 1);

    // Valid held high through PRESENT with junk data.
    w0 = windows;
    window(16'd1, 16'd2, 16'd3, 16'd4);
    window(16'd5, 16'd6, 16'd7, 16'd8);
    idle(4);
    check("held_valid_windows", windows - w0, 2);

    // Reset asserted between edges one cycle into PRESENT.
    window(16'd20, 16'd20, 16'd20, 16'd20);
    @(negedge clk);
    #2;
    reset = 1'b0;
    sample_valid = 1'b0;
    #1;
    check("async_enable", compare_enable, 0);
    check("async_ready", sample_ready, 0);
    check("async_data", compare_data_out, 0);
    check("async_wcount", window_count, 0);
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_rereset", sample_ready, 1);
    window(16'd3, 16'd3, 16'd3, 16'd3);
    idle(4);
    check("wcount_after_rereset", window_count, 1);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
